// File: rtl/clt_pkg.sv
// Shared types and width helpers for the CLT noise-statistics checker.
package clt_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StDone
    } clt_state_e;

    // Cycles spent in DRAIN while the square stage and accumulators finish the last sample.
    localparam int unsigned DrainCycles = 2;

    function automatic int unsigned sum_width(int unsigned in_w, int unsigned log2_win);
        return in_w + log2_win;
    endfunction

    function automatic int unsigned sq_width(int unsigned in_w, int unsigned log2_win);
        return 2 * in_w + log2_win;
    endfunction

endpackage

// File: rtl/clt_stat_monitor_if.sv
// Sample/control/result bundle of clt_stat_monitor; master drives samples, slave is the monitor.
interface clt_stat_monitor_if #(
    parameter int unsigned IN_WIDTH    = 14,
    parameter int unsigned LOG2_WINDOW = 10
);
    localparam int unsigned SUM_WIDTH = clt_pkg::sum_width(IN_WIDTH, LOG2_WINDOW);
    localparam int unsigned SQ_WIDTH  = clt_pkg::sq_width(IN_WIDTH, LOG2_WINDOW);

    logic                        start;
    logic signed [IN_WIDTH-1:0]  sample;
    logic                        sample_valid;
    logic                        ack;
    logic                        busy;
    logic                        done;
    logic signed [SUM_WIDTH-1:0] sum;
    logic [SQ_WIDTH-1:0]         sumsq;
    logic signed [IN_WIDTH-1:0]  smin;
    logic signed [IN_WIDTH-1:0]  smax;

    modport master (
        output start, sample, sample_valid, ack,
        input  busy, done, sum, sumsq, smin, smax
    );

    modport slave (
        input  start, sample, sample_valid, ack,
        output busy, done, sum, sumsq, smin, smax
    );

endinterface

// File: rtl/clt_sq_stage.sv
// Registered sample/square stage: captures an accepted sample and its unsigned square.
module clt_sq_stage #(
    parameter int unsigned IN_WIDTH = 14
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    input  logic signed [IN_WIDTH-1:0] in_sample_i,
    output logic                       out_valid_o,
    output logic signed [IN_WIDTH-1:0] out_sample_o,
    output logic [2*IN_WIDTH-1:0]      out_sq_o
);

    logic                       valid_q, valid_d;
    logic signed [IN_WIDTH-1:0] sample_q, sample_d;
    logic [2*IN_WIDTH-1:0]      sq_q, sq_d;
    logic signed [2*IN_WIDTH-1:0] prod;

    // A signed square is never negative, so the raw bits are the unsigned square.
    assign prod = in_sample_i * in_sample_i;

    always_comb begin
        valid_d  = in_valid_i;
        sample_d = sample_q;
        sq_d     = sq_q;
        if (in_valid_i) begin
            sample_d = in_sample_i;
            sq_d     = prod;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            sample_q <= '0;
            sq_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            sample_q <= sample_d;
            sq_q     <= sq_d;
        end
    end

    assign out_valid_o  = valid_q;
    assign out_sample_o = sample_q;
    assign out_sq_o     = sq_q;

endmodule

// File: rtl/clt_stat_monitor.sv
// Window statistics (sum, sum of squares, optional min/max) over 2^LOG2_WINDOW noise samples.
// Min/max tracking is built only when CLT_STAT_MINMAX_EN is defined.
module clt_stat_monitor
    import clt_pkg::*;
#(
    parameter int unsigned IN_WIDTH    = 14,
    parameter int unsigned LOG2_WINDOW = 10
) (
    input logic               clk,
    input logic               rst,
    clt_stat_monitor_if.slave bus
);

    localparam int unsigned SUM_WIDTH = sum_width(IN_WIDTH, LOG2_WINDOW);
    localparam int unsigned SQ_WIDTH  = sq_width(IN_WIDTH, LOG2_WINDOW);
    localparam logic [LOG2_WINDOW:0] CntLast = (LOG2_WINDOW + 1)'((1 << LOG2_WINDOW) - 1);
    localparam logic [1:0] DrainLast = 2'(DrainCycles - 1);

    clt_state_e                  state_q, state_d;
    logic [LOG2_WINDOW:0]        cnt_q, cnt_d;
    logic [1:0]                  drain_q, drain_d;
    logic                        accept, clear;
    logic                        stg_valid;
    logic signed [IN_WIDTH-1:0]  stg_sample;
    logic [2*IN_WIDTH-1:0]       stg_sq;
    logic signed [SUM_WIDTH-1:0] sum_q, sum_d;
    logic [SQ_WIDTH-1:0]         sumsq_q, sumsq_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        accept  = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StAccum;
                    cnt_d   = '0;
                    clear   = 1'b1;
                end
            end
            StAccum: begin
                if (bus.sample_valid) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) state_d = StDone;
                else                      drain_d = drain_q + 1'b1;
            end
            StDone: begin
                if (bus.ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    clt_sq_stage #(
        .IN_WIDTH(IN_WIDTH)
    ) u_sq_stage (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (accept),
        .in_sample_i  (bus.sample),
        .out_valid_o  (stg_valid),
        .out_sample_o (stg_sample),
        .out_sq_o     (stg_sq)
    );

    always_comb begin
        sum_d   = sum_q;
        sumsq_d = sumsq_q;
        if (clear) begin
            sum_d   = '0;
            sumsq_d = '0;
        end else if (stg_valid) begin
            sum_d   = sum_q + {{LOG2_WINDOW{stg_sample[IN_WIDTH-1]}}, stg_sample};
            sumsq_d = sumsq_q + {{LOG2_WINDOW{1'b0}}, stg_sq};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            sumsq_q <= '0;
        end else begin
            sum_q   <= sum_d;
            sumsq_q <= sumsq_d;
        end
    end

`ifdef CLT_STAT_MINMAX_EN
    localparam logic signed [IN_WIDTH-1:0] MaxPos = {1'b0, {(IN_WIDTH - 1){1'b1}}};
    localparam logic signed [IN_WIDTH-1:0] MinNeg = {1'b1, {(IN_WIDTH - 1){1'b0}}};

    logic signed [IN_WIDTH-1:0] min_q, min_d, max_q, max_d;

    // Extremes start at the opposite rails so the first sample always replaces both.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (clear) begin
            min_d = MaxPos;
            max_d = MinNeg;
        end else if (stg_valid) begin
            if (stg_sample < min_q) min_d = stg_sample;
            if (stg_sample > max_q) max_d = stg_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign bus.smin = min_q;
    assign bus.smax = max_q;
`else
    assign bus.smin = '0;
    assign bus.smax = '0;
`endif

    assign bus.busy  = (state_q == StAccum) || (state_q == StDrain);
    assign bus.done  = (state_q == StDone);
    assign bus.sum   = sum_q;
    assign bus.sumsq = sumsq_q;

endmodule

// File: tb/tb_clt_stat_monitor.sv
// Directed + randomized bench for clt_stat_monitor (LOG2_WINDOW=4) against a queue-based model.
module tb_clt_stat_monitor;

    localparam int unsigned IW = 14;
    localparam int unsigned LW = 4;
    localparam int unsigned N  = 16;
    localparam int unsigned SW = IW + LW;
    localparam int unsigned QW = 2 * IW + LW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clt_stat_monitor_if #(.IN_WIDTH(IW), .LOG2_WINDOW(LW)) bus ();

    clt_stat_monitor #(
        .IN_WIDTH    (IW),
        .LOG2_WINDOW (LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rand_sample();
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    // Expected results are recomputed from the list of accepted samples.
    task automatic check_results(string tag);
        longint s  = 0;
        longint ss = 0;
        int mn = (1 << (IW - 1)) - 1;
        int mx = -(1 << (IW - 1));
        logic signed [SW-1:0] es;
        logic [QW-1:0]        eq;
        logic signed [IW-1:0] emn, emx;
        foreach (q[i]) begin
            s  += q[i];
            ss += longint'(q[i]) * longint'(q[i]);
            if (q[i] < mn) mn = q[i];
            if (q[i] > mx) mx = q[i];
        end
        es = SW'(s);
        eq = QW'(ss);
`ifdef CLT_STAT_MINMAX_EN
        emn = IW'(mn);
        emx = IW'(mx);
`else
        emn = '0;
        emx = '0;
`endif
        check({tag, ".sum"}, bus.sum, es);
        check({tag, ".sumsq"}, bus.sumsq, eq);
        check({tag, ".smin"}, bus.smin, emn);
        check({tag, ".smax"}, bus.smax, emx);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, ".busy"}, bus.busy, 0);
        check({tag, ".done"}, bus.done, 0);
        check({tag, ".sum"}, bus.sum, 0);
        check({tag, ".sumsq"}, bus.sumsq, 0);
        check({tag, ".smin"}, bus.smin, 0);
        check({tag, ".smax"}, bus.smax, 0);
    endtask

    // mode 0: const 5, 1: alternating rails, 2: valid 1-0-0-1, 3: random valid/sample.
    task automatic run_window(string tag, int mode, bit start_noise, bit ack_noise);
        int  cyc = 0;
        bit  v;
        int  smp;
        q.delete();
        bus.start        = 1'b1;
        bus.sample_valid = 1'b0;
        bus.ack          = 1'b0;
        step();
        bus.start = 1'b0;
        check({tag, ".busy_rise"}, bus.busy, 1);
        check({tag, ".done_low"}, bus.done, 0);
        while (q.size() < N && cyc < 40 * N) begin
            case (mode)
                0:       begin v = 1'b1; smp = 5; end
                1:       begin v = 1'b1; smp = (q.size() % 2 == 0) ? 8191 : -8192; end
                2:       begin v = (cyc % 4 == 0) || (cyc % 4 == 3); smp = rand_sample(); end
                default: begin v = $urandom_range(0, 1) == 1; smp = rand_sample(); end
            endcase
            bus.sample_valid = v;
            bus.sample       = IW'(smp);
            bus.start        = start_noise && ($urandom_range(0, 3) == 0);
            bus.ack          = ack_noise && ($urandom_range(0, 3) == 0);
            step();
            if (v) q.push_back(smp);
            cyc++;
        end
        if (q.size() < N) check({tag, ".window_timeout"}, q.size(), N);
        // Extra samples, starts and acks during DRAIN must all be ignored.
        bus.sample_valid = 1'b1;
        bus.sample       = IW'(rand_sample());
        bus.start        = start_noise;
        bus.ack          = ack_noise;
        check({tag, ".drain_busy"}, bus.busy, 1);
        check({tag, ".drain_done0"}, bus.done, 0);
        step();
        check({tag, ".drain_done1"}, bus.done, 0);
        step();
        bus.sample_valid = 1'b0;
        bus.start        = 1'b0;
        bus.ack          = 1'b0;
        check({tag, ".done_rise"}, bus.done, 1);
        check({tag, ".busy_fall"}, bus.busy, 0);
        check_results(tag);
    endtask

    task automatic finish_ack(string tag);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        check({tag, ".ack_done"}, bus.done, 0);
        check({tag, ".ack_busy"}, bus.busy, 0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.sample       = '0;
        bus.sample_valid = 1'b0;
        bus.ack          = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;

        run_window("const5", 0, 1'b0, 1'b0);
        check("const5.sum_abs", bus.sum, 80);
        check("const5.sumsq_abs", bus.sumsq, 400);
        finish_ack("const5");

        run_window("rails", 1, 1'b0, 1'b0);
        check("rails.sum_abs", bus.sum, -8);
        check("rails.sumsq_abs", bus.sumsq, 1073610760);
        finish_ack("rails");

        run_window("gapped", 2, 1'b1, 1'b1);

        // Hold in DONE without ack, then ack and start together.
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold.done", bus.done, 1);
            check_results("hold");
        end
        bus.ack   = 1'b1;
        bus.start = 1'b1;
        step();
        bus.ack   = 1'b0;
        bus.start = 1'b0;
        check("ackstart.done", bus.done, 0);
        check("ackstart.busy", bus.busy, 0);
        step();
        step();
        check("ackstart.no_window", bus.busy, 0);
        check_results("idle_keep");

        // Reset after 7 of 16 samples discards the partial window.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.sample = IW'(rand_sample());
            step();
        end
        bus.sample_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("midreset");
        step();
        check("midreset.no_done", bus.done, 0);
        run_window("after_reset", 3, 1'b0, 1'b0);
        finish_ack("after_reset");

        for (int w = 0; w < 4; w++) begin
            run_window($sformatf("rand%0d", w), 3, 1'b1, 1'b1);
            finish_ack($sformatf("rand%0d", w));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
